uart_cmd_parser: RTL

//   Byte-stream command parser sitting directly downstream of the UART receiver.

---
 rtl/uart_cmd_parser.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream register-write frame parser; UART_CMD_CHK_EN adds a checksum byte
module uart_cmd_parser #(
    parameter int unsigned CLK           = 50_000_000,
    parameter int unsigned BPS           = 9600,
    parameter logic [7:0]  HEADER        = 8'hAA,
    parameter int unsigned TIMEOUT_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frm_err,
    output logic        busy
);

    localparam int unsigned TIMEOUT_CNT  = (CLK / BPS) * 10 * TIMEOUT_BYTES;
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATH,
        S_DATL,
        S_CHK
    } state_t;

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic [7:0]  addr_q;
    logic [7:0]  dh_q;
    logic        wr_en_q;
    logic [7:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        frm_err_q;
    logic        timeout;

`ifdef UART_CMD_CHK_EN
    logic [7:0]  dl_q;
    logic [7:0]  chk_sum;

    // 8-bit operands keep the sum modulo 256
    assign chk_sum = HEADER + addr_q + dh_q + dl_q;
`endif

    // A byte arriving on the expiry cycle takes priority over the timeout
    assign timeout = (state_q != S_IDLE) && !din_vld && (cnt_q == TIMEOUT_LAST);

    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (din_vld || (state_q == S_IDLE) || timeout) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            dh_q      <= '0;
`ifdef UART_CMD_CHK_EN
            dl_q      <= '0;
`endif
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            frm_err_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            frm_err_q <= 1'b0;
            cnt_q     <= cnt_d;
            if (timeout) begin
                state_q   <= S_IDLE;
                frm_err_q <= 1'b1;
            end else if (din_vld) begin
                case (state_q)
                    S_IDLE: begin
                        if (din == HEADER) begin
                            state_q <= S_ADDR;
                        end
                    end
                    S_ADDR: begin
                        addr_q  <= din;
                        state_q <= S_DATH;
                    end
                    S_DATH: begin
                        dh_q    <= din;
                        state_q <= S_DATL;
                    end
`ifdef UART_CMD_CHK_EN
                    S_DATL: begin
                        dl_q    <= din;
                        state_q <= S_CHK;
                    end
                    S_CHK: begin
                        if (din == chk_sum) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= {dh_q, dl_q};
                        end else begin
                            frm_err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
`else
                    S_DATL: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= {dh_q, din};
                        state_q   <= S_IDLE;
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign frm_err = frm_err_q;
    assign busy    = (state_q != S_IDLE);

endmodule
